// File: rtl/voice_mixer_pkg.sv
// Shared types and sizing helpers for voice_mixer: the FSM state enum and the
// accumulator width function.
package voice_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DIVIDE,
        DONE
    } state_t;

    // Wide enough to hold num_voices full-scale samples without overflow.
    function automatic int sum_width(input int in_w, input int num_voices);
        return in_w + $clog2(num_voices + 1);
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring serial divider: one quotient bit per cycle, W cycles per divide.
// The first iteration runs on the start edge; done pulses after the last one.
module serial_divider #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, quo_q, div_q;
    logic [CW-1:0] cnt_q;
    logic          run_q, zero_q, done_q;

    logic [W-1:0]  rem_in, quo_in, div_in, rem_nx, quo_nx;
    logic [W:0]    shifted, diff;

    // On start the step works straight from the incoming operands.
    always_comb begin
        rem_in  = start ? '0       : rem_q;
        quo_in  = start ? dividend : quo_q;
        div_in  = start ? divisor  : div_q;
        shifted = {rem_in, quo_in[W-1]};
        diff    = shifted - {1'b0, div_in};
        if (diff[W]) begin
            rem_nx = shifted[W-1:0];
            quo_nx = {quo_in[W-2:0], 1'b0};
        end else begin
            rem_nx = diff[W-1:0];
            quo_nx = {quo_in[W-2:0], 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= rem_nx;
                quo_q  <= quo_nx;
                div_q  <= divisor;
                zero_q <= (divisor == '0);
                cnt_q  <= CW'(1);
                run_q  <= 1'b1;
            end else if (run_q) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Division by zero yields zero rather than the all-ones restoring result.
    assign quotient = zero_q ? '0 : quo_q;
    assign done     = done_q;

endmodule

// File: rtl/voice_mixer.sv
// Sample-rate voice mixer: snapshots all voices on strobe, sums them serially and
// saturates to OUT_W. Define VOICE_MIXER_NORM_EN to average over non-zero voices.
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 13,
    parameter int IN_W       = 8,
    parameter int OUT_W      = 12
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       strobe,
    input  logic [NUM_VOICES*IN_W-1:0] voices,
    output logic [OUT_W-1:0]           mixed_sample,
    output logic                       sample_valid,
    output logic                       busy
);
    localparam int SUM_W = sum_width(IN_W, NUM_VOICES);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CMP_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam logic [CMP_W-1:0] OUT_MAX = CMP_W'({OUT_W{1'b1}});

    state_t                     state_q;
    logic [NUM_VOICES*IN_W-1:0] cap_q;
    logic [SUM_W-1:0]           acc_q, acc_next, result;
    logic [IDX_W-1:0]           idx_q;
    logic [IN_W-1:0]            cur_voice;
    logic                       last_voice;
    logic [CMP_W-1:0]           res_wide;
    logic [OUT_W-1:0]           res_sat;

    // The capture register shifts down one voice per ACCUM cycle.
    assign cur_voice  = cap_q[IN_W-1:0];
    assign acc_next   = acc_q + SUM_W'(cur_voice);
    assign last_voice = (idx_q == IDX_W'(NUM_VOICES - 1));

`ifdef VOICE_MIXER_NORM_EN
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic [SUM_W-1:0] quotient;
    logic             div_start, div_done;

    assign cnt_next  = cnt_q + CNT_W'(cur_voice != '0);
    // Launch on the last ACCUM cycle with the final totals so DIVIDE lasts SUM_W cycles.
    assign div_start = (state_q == ACCUM) && last_voice;

    serial_divider #(.W(SUM_W)) u_divider (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (div_start),
        .dividend (acc_next),
        .divisor  (SUM_W'(cnt_next)),
        .quotient (quotient),
        .done     (div_done)
    );

    always_ff @(posedge clk) begin
        if (!n_rst)
            cnt_q <= '0;
        else if (state_q == IDLE && strobe)
            cnt_q <= '0;
        else if (state_q == ACCUM)
            cnt_q <= cnt_next;
    end

    assign result = quotient;
`else
    assign result = acc_q;
`endif

    assign res_wide = CMP_W'(result);
    assign res_sat  = (res_wide > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : res_wide[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            cap_q        <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            mixed_sample <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (strobe) begin
                        cap_q   <= voices;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_next;
                    cap_q <= cap_q >> IN_W;
                    idx_q <= idx_q + 1'b1;
                    if (last_voice) begin
`ifdef VOICE_MIXER_NORM_EN
                        state_q <= DIVIDE;
`else
                        state_q <= DONE;
`endif
                    end
                end
`ifdef VOICE_MIXER_NORM_EN
                DIVIDE: begin
                    if (div_done)
                        state_q <= DONE;
                end
`endif
                DONE: begin
                    mixed_sample <= res_sat;
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: two instances (OUT_W=12 and OUT_W=8) share the
// same stimulus; expectations follow whether VOICE_MIXER_NORM_EN is defined.
module tb_voice_mixer;
    localparam int NV   = 13;
    localparam int IN_W = 8;
    localparam int VW   = NV * IN_W;
`ifdef VOICE_MIXER_NORM_EN
    localparam bit NORM = 1'b1;
    localparam int LAT  = 26;
`else
    localparam bit NORM = 1'b0;
    localparam int LAT  = 14;
`endif

    typedef logic [IN_W-1:0] vlist_t [NV];

    logic          clk = 1'b0;
    logic          n_rst;
    logic          strobe;
    logic [VW-1:0] voices;
    logic [11:0]   mix_a;
    logic [7:0]    mix_b;
    logic          valid_a, valid_b, busy_a, busy_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    voice_mixer #(.NUM_VOICES(NV), .IN_W(IN_W), .OUT_W(12)) dut_a (
        .clk          (clk),
        .n_rst        (n_rst),
        .strobe       (strobe),
        .voices       (voices),
        .mixed_sample (mix_a),
        .sample_valid (valid_a),
        .busy         (busy_a)
    );

    voice_mixer #(.NUM_VOICES(NV), .IN_W(IN_W), .OUT_W(8)) dut_b (
        .clk          (clk),
        .n_rst        (n_rst),
        .strobe       (strobe),
        .voices       (voices),
        .mixed_sample (mix_b),
        .sample_valid (valid_b),
        .busy         (busy_b)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack(input vlist_t v);
        logic [VW-1:0] p;
        p = '0;
        for (int k = 0; k < NV; k++) p[k*IN_W +: IN_W] = v[k];
        return p;
    endfunction

    // One mix; optionally re-strobes and scrambles voices five cycles in.
    task automatic run_mix(input string tag, input vlist_t v, input int exp_a,
                           input int exp_b, input bit disturb);
        int pulses_a = 0;
        int pulses_b = 0;
        int first    = -1;
        int got_a    = -1;
        int got_b    = -1;
        @(negedge clk);
        voices = pack(v);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        check({tag, ".busy_start"}, int'(busy_a), 1);
        for (int i = 1; i <= LAT + 20; i++) begin
            @(posedge clk);
            #1;
            if (valid_a) begin
                pulses_a++;
                if (first < 0) begin
                    first = i;
                    got_a = int'(mix_a);
                end
            end
            if (valid_b) begin
                pulses_b++;
                if (got_b < 0) got_b = int'(mix_b);
            end
            if (disturb && i == 5) begin
                strobe = 1'b1;
                voices = {VW{1'b1}};
            end
            if (disturb && i == 6) strobe = 1'b0;
        end
        check({tag, ".latency"},  first,    LAT);
        check({tag, ".pulses_a"}, pulses_a, 1);
        check({tag, ".pulses_b"}, pulses_b, 1);
        check({tag, ".mix_a"},    got_a,    exp_a);
        check({tag, ".mix_b"},    got_b,    exp_b);
        check({tag, ".busy_end"}, int'(busy_a), 0);
        check({tag, ".hold_a"},   int'(mix_a), exp_a);
    endtask

    // Starts a mix and pulls reset late in it (DIVIDE with norm, ACCUM without).
    task automatic abort_mix(input vlist_t v);
        int pulses = 0;
        @(negedge clk);
        voices = pack(v);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        for (int i = 1; i <= LAT - 2; i++) begin
            @(posedge clk);
            #1;
            if (valid_a || valid_b) pulses++;
            if (i == LAT - 4) n_rst = 1'b0;
        end
        n_rst = 1'b1;
        check("abort.pulses", pulses, 0);
        check("abort.mix_a",  int'(mix_a),   0);
        check("abort.mix_b",  int'(mix_b),   0);
        check("abort.busy",   int'(busy_a),  0);
        check("abort.valid",  int'(valid_a), 0);
    endtask

    initial begin
        vlist_t vec;
        n_rst  = 1'b0;
        strobe = 1'b0;
        voices = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.mix_a",   int'(mix_a),   0);
        check("reset.mix_b",   int'(mix_b),   0);
        check("reset.valid_a", int'(valid_a), 0);
        check("reset.valid_b", int'(valid_b), 0);
        check("reset.busy_a",  int'(busy_a),  0);
        check("reset.busy_b",  int'(busy_b),  0);
        n_rst = 1'b1;

        vec = '{default: 8'd0};
        run_mix("all_zero", vec, 0, 0, 1'b0);

        vec = '{0: 8'd100, 1: 8'd50, default: 8'd0};
        run_mix("avg2", vec, NORM ? 75 : 150, NORM ? 75 : 150, 1'b0);

        vec = '{0: 8'd10, 1: 8'd11, default: 8'd0};
        run_mix("trunc", vec, NORM ? 10 : 21, NORM ? 10 : 21, 1'b0);

        vec = '{default: 8'd255};
        run_mix("all_full", vec, NORM ? 255 : 3315, 255, 1'b0);

        vec = '{0: 8'd100, 1: 8'd200, default: 8'd0};
        run_mix("sat8", vec, NORM ? 150 : 300, NORM ? 150 : 255, 1'b0);

        vec = '{0: 8'd1, 1: 8'd2, 2: 8'd3, 3: 8'd4, 4: 8'd250, default: 8'd0};
        run_mix("five", vec, NORM ? 52 : 260, NORM ? 52 : 255, 1'b0);

        vec = '{0: 8'd100, 1: 8'd50, default: 8'd0};
        run_mix("disturb", vec, NORM ? 75 : 150, NORM ? 75 : 150, 1'b1);

        vec = '{default: 8'd255};
        abort_mix(vec);

        vec = '{0: 8'd10, 1: 8'd11, default: 8'd0};
        run_mix("post_reset", vec, NORM ? 10 : 21, NORM ? 10 : 21, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
